// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of the single-port data memory between
// the pipeline port (C) and the debug/DMA port (D), one access per 3 cycles.
// Optional build macro DMEM_ALIGN_CHK_EN adds misalignment errors.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [2:0]        i_c_size,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic              o_c_err,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [2:0]        i_d_size,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_err,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  output logic [2:0]        o_m_size,
  input  logic [DATA_W-1:0] i_m_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic r_owner, r_last, r_we, r_err;
  logic [2:0] r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic w_sel_d, w_err;
  logic [2:0] w_size;
  logic [ADDR_W-1:0] w_addr;
  // owner encoding: 0 = C, 1 = D; on a tie the port not granted last wins
  assign w_sel_d = i_d_req & (~i_c_req | ~r_last);
  assign w_size  = w_sel_d ? i_d_size : i_c_size;
  assign w_addr  = w_sel_d ? i_d_addr : i_c_addr;
`ifdef DMEM_ALIGN_CHK_EN
  assign w_err = (w_size[1:0] == 2'b11) | ((w_size[1:0] == 2'b00) & (|w_addr[1:0])) |
                 ((w_size[1:0] == 2'b10) & w_addr[0]);
`else
  assign w_err = (w_size[1:0] == 2'b11);
`endif
  assign o_m_addr  = r_addr;
  assign o_m_wdata = r_wdata;
  assign o_m_size  = r_size;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state and per-port handshake outputs
  always_comb begin
    w_next     = IDLE;
    o_m_we     = 1'b0;
    o_c_gnt    = 1'b0;
    o_d_gnt    = 1'b0;
    o_c_rvalid = 1'b0;
    o_d_rvalid = 1'b0;
    o_c_rdata  = '0;
    o_d_rdata  = '0;
    o_c_err    = 1'b0;
    o_d_err    = 1'b0;
    case (r_state)
      IDLE:   w_next = (i_c_req | i_d_req) ? ACCESS : IDLE;
      ACCESS: begin
        w_next  = RESP;
        o_m_we  = r_we & ~r_err;
        o_c_gnt = ~r_owner;
        o_d_gnt = r_owner;
      end
      RESP: begin
        o_c_rvalid = ~r_owner;
        o_d_rvalid = r_owner;
        o_c_rdata  = r_owner ? '0 : r_rdata;
        o_d_rdata  = r_owner ? r_rdata : '0;
        o_c_err    = ~r_owner & r_err;
        o_d_err    = r_owner & r_err;
      end
      default: w_next = IDLE;
    endcase
  end
  // latch the winning command and remember who won for the next tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && (i_c_req | i_d_req)) begin
      r_owner <= w_sel_d;
      r_last  <= w_sel_d;
      r_we    <= w_sel_d ? i_d_we : i_c_we;
      r_err   <= w_err;
      r_size  <= w_size;
      r_addr  <= w_addr;
      r_wdata <= w_sel_d ? i_d_wdata : i_c_wdata;
    end
  // capture memory read data; writes and errors return zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else if (r_state == ACCESS) r_rdata <= (r_we | r_err) ? '0 : i_m_rdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of arbitration, latency, errors and reset
module tb_dmem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [2:0] c_size = 0, d_size = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, m_we;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0] m_size;
  int errors = 0, checks = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_size(c_size), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata), .o_c_err(c_err),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_size(m_size), .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt, c_rvalid, d_rvalid, m_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {c_gnt, d_gnt, c_rvalid, d_rvalid, m_we}); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", m_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt, m_we} !== 3'b0) begin errors++; $display("FAIL idle_ctrl: got %b want 000", {c_gnt, d_gnt, m_we}); end
  endtask

  task automatic test_c_write();
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_size = 3'b000; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; m_rdata = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt, m_we} !== 3'b101) begin errors++; $display("FAIL cw_gnt: got %b want 101", {c_gnt, d_gnt, m_we}); end
    checks++; if (m_addr !== 32'h10) begin errors++; $display("FAIL cw_addr: got %h want 10", m_addr); end
    checks++; if (m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cw_wdata: got %h want deadbeef", m_wdata); end
    @(posedge clk); #1;
    c_req = 0;
    @(negedge clk);
    checks++; if ({c_rvalid, c_err, d_rvalid, m_we, c_gnt} !== 5'b10000) begin errors++; $display("FAIL cw_resp: got %b want 10000", {c_rvalid, c_err, d_rvalid, m_we, c_gnt}); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL cw_rdata: got %h want 0", c_rdata); end
  endtask

  task automatic test_d_read();
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_size = 3'b001; d_addr = 32'h11; m_rdata = 32'hFFFFFF80;
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk);
    checks++; if ({d_gnt, c_gnt, m_we} !== 3'b100) begin errors++; $display("FAIL dr_gnt: got %b want 100", {d_gnt, c_gnt, m_we}); end
    checks++; if ({m_addr, m_size} !== {32'h11, 3'b001}) begin errors++; $display("FAIL dr_cmd: got %h/%b want 11/001", m_addr, m_size); end
    @(negedge clk);
    checks++; if ({d_rvalid, d_err, c_rvalid, c_gnt} !== 4'b1000) begin errors++; $display("FAIL dr_resp: got %b want 1000", {d_rvalid, d_err, c_rvalid, c_gnt}); end
    checks++; if (d_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL dr_rdata: got %h want ffffff80", d_rdata); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL dr_c_rdata: got %h want 0", c_rdata); end
  endtask

  task automatic test_round_robin();
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_size = 0; c_addr = 32'h0; d_req = 1; d_we = 0; d_size = 0; d_addr = 32'h4;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt} !== {(i == 1 || i == 7), (i == 4 || i == 10)}) begin
        errors++; $display("FAIL rr_cycle%0d: got c=%b d=%b want c=%b d=%b", i, c_gnt, d_gnt, (i == 1 || i == 7), (i == 4 || i == 10));
      end
    end
    c_req = 0; d_req = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rsvd_size();
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_size = 3'b011; c_addr = 32'h20; c_wdata = 32'h1234; m_rdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({c_gnt, m_we} !== 2'b10) begin errors++; $display("FAIL rs_access: got %b want 10", {c_gnt, m_we}); end
    @(posedge clk); #1;
    c_req = 0;
    @(negedge clk);
    checks++; if ({c_rvalid, c_err, m_we} !== 3'b110) begin errors++; $display("FAIL rs_resp: got %b want 110", {c_rvalid, c_err, m_we}); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL rs_rdata: got %h want 0", c_rdata); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_size = 3'b010; d_addr = 32'h40; d_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({d_gnt, m_we} !== 2'b11) begin errors++; $display("FAIL rm_access: got %b want 11", {d_gnt, m_we}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({d_gnt, m_we, m_size} !== 5'b0) begin errors++; $display("FAIL rm_ctrl: got %b want 00000", {d_gnt, m_we, m_size}); end
    checks++; if ({m_addr, m_wdata} !== 64'h0) begin errors++; $display("FAIL rm_data: got %h/%h want 0/0", m_addr, m_wdata); end
    @(negedge clk);
    checks++; if ({d_rvalid, d_gnt} !== 2'b00) begin errors++; $display("FAIL rm_noresp: got %b want 00", {d_rvalid, d_gnt}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({d_gnt, m_we, m_addr} !== {2'b11, 32'h40}) begin errors++; $display("FAIL rm_retry: got %b%b %h want 11 40", d_gnt, m_we, m_addr); end
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk);
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rm_resp: got %b%b %h want 10 0", d_rvalid, d_err, d_rdata); end
  endtask

  task automatic test_align();
    logic exp_err;
    logic [31:0] exp_rdata;
`ifdef DMEM_ALIGN_CHK_EN
    exp_err = 1'b1; exp_rdata = 32'h0;
`else
    exp_err = 1'b0; exp_rdata = 32'hCAFEF00D;
`endif
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_size = 3'b000; c_addr = 32'h6; m_rdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({c_gnt, m_we, m_addr} !== {2'b10, 32'h6}) begin errors++; $display("FAIL al_access: got %b%b %h want 10 6", c_gnt, m_we, m_addr); end
    @(posedge clk); #1;
    c_req = 0;
    @(negedge clk);
    checks++; if ({c_rvalid, c_err} !== {1'b1, exp_err}) begin errors++; $display("FAIL al_err: got %b%b want 1%b", c_rvalid, c_err, exp_err); end
    checks++; if (c_rdata !== exp_rdata) begin errors++; $display("FAIL al_rdata: got %h want %h", c_rdata, exp_rdata); end
  endtask

  initial begin
    test_reset();
    test_c_write();
    test_d_read();
    test_round_robin();
    test_rsvd_size();
    test_reset_mid();
    test_align();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
